// File: rtl/sb_cfg_chain_param_if.sv
// Configuration-chain bus for sb_cfg_chain_param: serial shift side plus
// commit handshake and the committed mux-select word.
interface sb_cfg_chain_param_if #(
  parameter int unsigned NUM_MUX  = 6,
  parameter int unsigned SEL_BITS = 6
);
  localparam int unsigned CHAIN_LEN = NUM_MUX * SEL_BITS;

  logic                 ccff_head;
  logic                 ccff_en;
  logic                 cfg_load;
  logic                 cfg_par_in;
  logic                 ccff_tail;
  logic [CHAIN_LEN-1:0] mem_out;
  logic [CHAIN_LEN-1:0] mem_outb;
  logic                 cfg_full;
  logic                 cfg_valid;
  logic                 cfg_ack;
  logic                 cfg_err;

  modport master (
    output ccff_head, ccff_en, cfg_load, cfg_par_in,
    input  ccff_tail, mem_out, mem_outb, cfg_full, cfg_valid, cfg_ack, cfg_err
  );

  modport slave (
    input  ccff_head, ccff_en, cfg_load, cfg_par_in,
    output ccff_tail, mem_out, mem_outb, cfg_full, cfg_valid, cfg_ack, cfg_err
  );
endinterface

// File: rtl/sb_cfg_chain_param.sv
// Serial configuration chain segment with a committed shadow copy driving NUM_MUX muxes.
// Define SB_CFG_PARITY_CHECK_EN to additionally gate commits on frame even parity.
module sb_cfg_chain_param #(
  parameter int unsigned NUM_MUX  = 6,
  parameter int unsigned SEL_BITS = 6
) (
  input  logic                prog_clk,
  input  logic                pReset,
  sb_cfg_chain_param_if.slave cfg
);

  localparam int unsigned CHAIN_LEN = NUM_MUX * SEL_BITS;
  localparam int unsigned CW        = $clog2(CHAIN_LEN + 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  logic [CHAIN_LEN-1:0] sr_q, sr_d, sr_shift;
  logic [CHAIN_LEN-1:0] active_q, activeb_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  state_e               state_q, state_d;
  logic                 full_q, valid_q, ack_q, err_q;
  logic                 parity_ok, accept, reject;

  // Head enters at bit 0; a single-bit chain just replaces its only bit.
  if (CHAIN_LEN > 1) begin : g_shift
    assign sr_shift = {sr_q[CHAIN_LEN-2:0], cfg.ccff_head};
  end else begin : g_shift1
    assign sr_shift = cfg.ccff_head;
  end

`ifndef SB_CFG_PARITY_CHECK_EN
  logic par_in_unused;
  assign par_in_unused = cfg.cfg_par_in;
`endif

  // Commit decision and next shift/count state.
  always_comb begin
    parity_ok = 1'b1;
`ifdef SB_CFG_PARITY_CHECK_EN
    parity_ok = ((^sr_q) == cfg.cfg_par_in);
`endif
    accept = cfg.cfg_load && (state_q == ST_FULL) && parity_ok;
    reject = cfg.cfg_load && !accept;

    sr_d = sr_q;
    if (cfg.ccff_en) sr_d = sr_shift;

    // Counter saturates at CHAIN_LEN; bits keep flowing through to the tail.
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = cfg.ccff_en ? CW'(1) : '0;
    end else if (cfg.ccff_en && (cnt_q != CW'(CHAIN_LEN))) begin
      cnt_d = cnt_q + CW'(1);
    end

    if (cnt_d == '0) begin
      state_d = ST_EMPTY;
    end else if (cnt_d == CW'(CHAIN_LEN)) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_FILLING;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      state_q   <= ST_EMPTY;
      active_q  <= '0;
      activeb_q <= '1;
      full_q    <= 1'b0;
      valid_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      full_q  <= (state_d == ST_FULL);
      ack_q   <= accept;
      // Capture the frame as it stood before this edge's shift.
      if (accept) begin
        active_q  <= sr_q;
        activeb_q <= ~sr_q;
        valid_q   <= 1'b1;
      end
      if (reject) err_q <= 1'b1;
    end
  end

  assign cfg.ccff_tail = sr_q[CHAIN_LEN-1];
  assign cfg.mem_out   = active_q;
  assign cfg.mem_outb  = activeb_q;
  assign cfg.cfg_full  = full_q;
  assign cfg.cfg_valid = valid_q;
  assign cfg.cfg_ack   = ack_q;
  assign cfg.cfg_err   = err_q;

endmodule

// File: tb/tb_sb_cfg_chain_param.sv
// Directed bench for sb_cfg_chain_param; committed frames are queued when the
// load is driven and popped when the acknowledge appears.
module tb_sb_cfg_chain_param;

  localparam int unsigned NUM_MUX   = 6;
  localparam int unsigned SEL_BITS  = 6;
  localparam int unsigned CHAIN_LEN = NUM_MUX * SEL_BITS;

  logic prog_clk = 1'b0;
  logic pReset   = 1'b1;

  always #5 prog_clk = ~prog_clk;

  sb_cfg_chain_param_if #(.NUM_MUX(NUM_MUX), .SEL_BITS(SEL_BITS)) cfg ();

  sb_cfg_chain_param #(.NUM_MUX(NUM_MUX), .SEL_BITS(SEL_BITS)) dut (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .cfg      (cfg)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [CHAIN_LEN-1:0] exp_q[$];
  logic [63:0] rnd_pat;
  logic [CHAIN_LEN-1:0] ones_v;
  logic [CHAIN_LEN-1:0] zeros_v;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle just after the edge.
  task automatic step(input logic head, input logic en, input logic load, input logic par);
    cfg.ccff_head  = head;
    cfg.ccff_en    = en;
    cfg.cfg_load   = load;
    cfg.cfg_par_in = par;
    @(posedge prog_clk);
    #1;
  endtask

  task automatic shift_bits(input logic [63:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) step(pat[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic commit(input string tag, input logic [CHAIN_LEN-1:0] exp,
                        input logic head, input logic en, input logic par);
    logic [CHAIN_LEN-1:0] got_exp;
    logic [CHAIN_LEN-1:0] got_expb;
    exp_q.push_back(exp);
    step(head, en, 1'b1, par);
    chk({tag, " ack"}, 64'(cfg.cfg_ack), 64'(1'b1));
    if (exp_q.size() == 0) begin
      chk({tag, " queue"}, 64'(0), 64'(1));
    end else if (cfg.cfg_ack === 1'b1) begin
      got_exp  = exp_q.pop_front();
      got_expb = ~got_exp;
      chk({tag, " mem_out"},  64'(cfg.mem_out),  64'(got_exp));
      chk({tag, " mem_outb"}, 64'(cfg.mem_outb), 64'(got_expb));
      chk({tag, " valid"},    64'(cfg.cfg_valid), 64'(1'b1));
      chk({tag, " full"},     64'(cfg.cfg_full),  64'(1'b0));
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " mem_out"},  64'(cfg.mem_out),   64'(zeros_v));
    chk({tag, " mem_outb"}, 64'(cfg.mem_outb),  64'(ones_v));
    chk({tag, " tail"},     64'(cfg.ccff_tail), 64'(1'b0));
    chk({tag, " full"},     64'(cfg.cfg_full),  64'(1'b0));
    chk({tag, " valid"},    64'(cfg.cfg_valid), 64'(1'b0));
    chk({tag, " ack"},      64'(cfg.cfg_ack),   64'(1'b0));
    chk({tag, " err"},      64'(cfg.cfg_err),   64'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    ones_v  = '1;
    zeros_v = '0;
    cfg.ccff_head  = 1'b0;
    cfg.ccff_en    = 1'b0;
    cfg.cfg_load   = 1'b0;
    cfg.cfg_par_in = 1'b0;

    // Reset overrides shift and load driven in the same cycles.
    pReset = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    pReset = 1'b0;
    chk_reset_state("reset");

    // Frame 0xA5A5A5A5A; tail reaches the first bit only after the 36th shift.
    shift_bits(64'h5_2D2D_2D2D, 35);
    chk("a5 full@35", 64'(cfg.cfg_full),  64'(1'b0));
    chk("a5 tail@35", 64'(cfg.ccff_tail), 64'(1'b0));
    shift_bits(64'h0, 1);
    chk("a5 full@36", 64'(cfg.cfg_full),  64'(1'b1));
    chk("a5 tail@36", 64'(cfg.ccff_tail), 64'(1'b1));
    commit("a5", 36'hA5A5A5A5A, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("a5 ack pulse", 64'(cfg.cfg_ack), 64'(1'b0));
    chk("a5 err clean", 64'(cfg.cfg_err), 64'(1'b0));

    // Early load after 20 bits is rejected; frame completes after 16 more.
    shift_bits(64'hABCDE, 20);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("early err",     64'(cfg.cfg_err),  64'(1'b1));
    chk("early ack",     64'(cfg.cfg_ack),  64'(1'b0));
    chk("early mem_out", 64'(cfg.mem_out),  64'(36'hA5A5A5A5A));
    chk("early full",    64'(cfg.cfg_full), 64'(1'b0));
    shift_bits(64'h091A, 15);
    chk("early full@35", 64'(cfg.cfg_full), 64'(1'b0));
    shift_bits(64'h0, 1);
    chk("early full@36", 64'(cfg.cfg_full), 64'(1'b1));
    commit("late", 36'hABCDE1234, 1'b0, 1'b0, 1'b0);

    // 40 continuous shifts: pass-through at tail, commit keeps the last 36.
    rnd_pat = {$urandom, $urandom};
    for (int k = 0; k < 40; k++) begin
      step(rnd_pat[39 - k], 1'b1, 1'b0, 1'b0);
      if (k == 35) chk("pass tail bit0", 64'(cfg.ccff_tail), 64'(rnd_pat[39]));
      if (k == 36) chk("pass tail bit1", 64'(cfg.ccff_tail), 64'(rnd_pat[38]));
    end
    chk("pass full", 64'(cfg.cfg_full), 64'(1'b1));
    commit("pass", rnd_pat[35:0], 1'b0, 1'b0, 1'b0);

    // Commit with a simultaneous shift of a 1: counter restarts at 1.
    shift_bits(64'h0_F0F0_F0F0, 36);
    commit("simul", 36'h0F0F0F0F0, 1'b1, 1'b1, 1'b0);
    shift_bits(64'h0, 34);
    chk("simul full@35", 64'(cfg.cfg_full), 64'(1'b0));
    shift_bits(64'h0, 1);
    chk("simul full@36", 64'(cfg.cfg_full),  64'(1'b1));
    chk("simul tail",    64'(cfg.ccff_tail), 64'(1'b1));
    commit("simul2", 36'h800000000, 1'b0, 1'b0, 1'b0);

    // Load held high: only one acknowledge per frame.
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("hold ack",     64'(cfg.cfg_ack), 64'(1'b0));
      chk("hold mem_out", 64'(cfg.mem_out), 64'(36'h800000000));
    end

    // Reset mid-frame discards the partial frame.
    shift_bits(64'h2AAA_AAAA, 30);
    pReset = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    pReset = 1'b0;
    chk_reset_state("midreset");
    shift_bits(64'h0_91A2_B3C4, 35);
    chk("post full@35", 64'(cfg.cfg_full), 64'(1'b0));
    shift_bits(64'h1, 1);
    chk("post full@36", 64'(cfg.cfg_full), 64'(1'b1));
    commit("post", 36'h123456789, 1'b0, 1'b0, 1'b0);

    // Frame of all ones has even parity 0.
    shift_bits(64'hF_FFFF_FFFF, 36);
`ifdef SB_CFG_PARITY_CHECK_EN
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("par bad ack",     64'(cfg.cfg_ack),  64'(1'b0));
    chk("par bad err",     64'(cfg.cfg_err),  64'(1'b1));
    chk("par bad full",    64'(cfg.cfg_full), 64'(1'b1));
    chk("par bad mem_out", 64'(cfg.mem_out),  64'(36'h123456789));
    commit("par good", ones_v, 1'b0, 1'b0, 1'b0);
`else
    commit("par ignored", ones_v, 1'b0, 1'b0, 1'b1);
    chk("par ignored err", 64'(cfg.cfg_err), 64'(1'b0));
`endif

    chk("queue drained", 64'(exp_q.size()), 64'(0));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sb_cfg_chain_param.md
SB_CFG_CHAIN_PARAM -- requirements
Module: sb_cfg_chain_param

Interface
REQ-001 Parameter NUM_MUX, default 6: number of routing multiplexers configured by this chain segment, range 1..64.
REQ-002 Parameter SEL_BITS, default 6: configuration bits per multiplexer, range 1..8.
REQ-003 Derived CHAIN_LEN = NUM_MUX*SEL_BITS; CW = clog2(CHAIN_LEN+1).
REQ-004 prog_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 pReset  input  1  reset, synchronous, active-high.
REQ-006 ccff_head  input  1  serial configuration bit in.
REQ-007 ccff_en  input  1  shift enable; one bit shifted per cycle when high.
REQ-008 cfg_load  input  1  request to commit the shift register to the active configuration.
REQ-009 cfg_par_in  input  1  expected even-parity bit of the frame, sampled with cfg_load.
REQ-010 ccff_tail  output  1  serial configuration bit out to the next chain segment.
REQ-011 mem_out  output  CHAIN_LEN  active configuration; bits [k*SEL_BITS +: SEL_BITS] drive mux k.
REQ-012 mem_outb  output  CHAIN_LEN  bitwise complement of mem_out.
REQ-013 cfg_full  output  1  CHAIN_LEN bits received since last commit or reset.
REQ-014 cfg_valid  output  1  active configuration has been committed at least once since reset.
REQ-015 cfg_ack  output  1  one-cycle pulse, commit accepted.
REQ-016 cfg_err  output  1  sticky, a commit was rejected.

Function
REQ-017 Shift register SR[CHAIN_LEN-1:0]: when ccff_en=1, SR <= {SR[CHAIN_LEN-2:0], ccff_head}; otherwise SR holds.
REQ-018 ccff_tail SHALL equal SR[CHAIN_LEN-1] directly from the register, giving CHAIN_LEN-cycle head-to-tail latency.
REQ-019 Bit counter CNT (CW bits) SHALL increment on each ccff_en cycle and saturate at CHAIN_LEN; shifting continues while saturated (pass-through to downstream segment).
REQ-020 State is EMPTY (CNT=0), FILLING (0<CNT<CHAIN_LEN) or FULL (CNT=CHAIN_LEN); cfg_full=1 only in FULL.
REQ-021 A commit SHALL be accepted when cfg_load=1 and state is FULL (and parity passes when REQ-031 applies): ACTIVE <= SR as it stood before the edge, cfg_valid <= 1, cfg_ack=1 for the following cycle.
REQ-022 Accepted commit SHALL reset CNT to 0, or to 1 if ccff_en=1 in the same cycle; the simultaneous shift still updates SR.
REQ-023 cfg_load outside FULL SHALL be rejected: ACTIVE, CNT unchanged, cfg_err <= 1, no cfg_ack.
REQ-024 cfg_load held high over multiple cycles SHALL produce at most one accepted commit per full frame.
REQ-025 mem_out = ACTIVE, mem_outb = ~ACTIVE, registered; never change except on accepted commit or reset.
REQ-026 cfg_err SHALL clear only on reset.

Reset
REQ-027 pReset=1 at a clock edge: SR=0, CNT=0, ACTIVE=0 (mem_out all 0, mem_outb all 1), ccff_tail=0, cfg_valid=0, cfg_ack=0, cfg_err=0.
REQ-028 pReset SHALL override ccff_en and cfg_load in the same cycle; reset mid-frame discards partial frame.
REQ-029 First shift accepted on the cycle after pReset deasserts.

Configuration
REQ-030 Macro SB_CFG_PARITY_CHECK_EN selects frame parity checking.
REQ-031 Defined: commit additionally requires XOR-reduction of SR equal to cfg_par_in; mismatch rejected per REQ-023 and CNT stays at CHAIN_LEN.
REQ-032 Undefined: cfg_par_in ignored, port retained; commit depends only on REQ-021 state condition.

Verification (defaults, CHAIN_LEN=36)
REQ-033 Reset, then shift 36 bits pattern 0xA5A5A5A5A on ccff_en, cfg_load -> next cycle cfg_ack=1, mem_out=0xA5A5A5A5A, mem_outb=0x5A5A5A5A5, cfg_valid=1, cfg_full=0.
REQ-034 Shift 20 bits, cfg_load -> cfg_err=1, mem_out unchanged, CNT=20, no cfg_ack; 16 more bits then cfg_load -> accepted.
REQ-035 Shift 40 bits with ccff_en continuous -> ccff_tail presents bit 0 at cycle 36 after first shift, CNT saturated at 36, commit captures last 36 bits.
REQ-036 Full frame, cfg_load and ccff_en together with ccff_head=1 -> ACTIVE=pre-edge SR, CNT=1, SR[0]=1.
REQ-037 pReset pulsed after 30 shifts of a second frame -> all outputs to REQ-027 values, cfg_valid=0, mem_out=0.
REQ-038 With SB_CFG_PARITY_CHECK_EN, frame of 36 ones and cfg_par_in=1 -> rejected, cfg_err=1; cfg_par_in=0 -> accepted.
